// File: rtl/sonar_varredura_uc.sv
// Sonar sweep control unit: measure, send an N_DIGITOS frame, bounce the servo position, wait, repeat.
// Optional measurement timeout is built only when SONAR_TIMEOUT_EN is defined.
module sonar_varredura_uc #(
    parameter int N_DIGITOS  = 7,
    parameter int N_POSICOES = 8,
    parameter int INTERVALO  = 2_000_000,
    parameter int TIMEOUT    = 3_000_000,
    localparam int DW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1,
    localparam int PW = $clog2(N_POSICOES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ligar,
    input  logic          modo,
    input  logic          fim_medida,
    input  logic          fim_transmissao,
    output logic          zera,
    output logic          medir_distancia,
    output logic          transmitir,
    output logic [DW-1:0] digito,
    output logic [PW-1:0] posicao,
    output logic          sentido,
    output logic          erro_medida,
    output logic          pronto,
    output logic [3:0]    db_estado
);

    localparam int IW = $clog2(INTERVALO + 1);

    typedef enum logic [3:0] {
        INICIAL            = 4'h0,
        PREPARACAO         = 4'h1,
        MEDIR              = 4'h2,
        ESPERA_MEDIDA      = 4'h3,
        TRANSMISSAO        = 4'h4,
        ESPERA_TRANSMISSAO = 4'h5,
        PROXIMO_DIGITO     = 4'h6,
        PROXIMA_POSICAO    = 4'h7,
        ESPERA_INTERVALO   = 4'h8,
        TIMEOUT_MEDIDA     = 4'h9,
        FIM_VARREDURA      = 4'hA
    } estado_t;

    estado_t       state, state_next;
    logic [IW-1:0] int_cnt;
    logic          fim_intervalo;
    logic          ultimo_digito;
    logic          fim_timeout;

    assign fim_intervalo = (int_cnt == IW'(INTERVALO - 1));
    assign ultimo_digito = (digito == DW'(N_DIGITOS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        zera            = 1'b0;
        medir_distancia = 1'b0;
        transmitir      = 1'b0;
        pronto          = 1'b0;
        db_estado       = state;
        case (state)
            INICIAL: begin
                zera = 1'b1;
                if (ligar) state_next = PREPARACAO;
            end
            PREPARACAO: begin
                zera       = 1'b1;
                state_next = MEDIR;
            end
            MEDIR: begin
                medir_distancia = 1'b1;
                state_next      = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                // a measurement arriving on the terminal count still counts as good
                if (fim_medida)       state_next = TRANSMISSAO;
                else if (fim_timeout) state_next = TIMEOUT_MEDIDA;
            end
            TIMEOUT_MEDIDA:   state_next = TRANSMISSAO;
            TRANSMISSAO: begin
                transmitir = 1'b1;
                state_next = ESPERA_TRANSMISSAO;
            end
            ESPERA_TRANSMISSAO: begin
                if (fim_transmissao)
                    state_next = ultimo_digito ? PROXIMA_POSICAO : PROXIMO_DIGITO;
            end
            PROXIMO_DIGITO:   state_next = TRANSMISSAO;
            PROXIMA_POSICAO: begin
                // single sweep ends after the frame taken at position 1 on the way down
                if (modo && !sentido && posicao == PW'(1)) state_next = FIM_VARREDURA;
                else                                       state_next = ESPERA_INTERVALO;
            end
            ESPERA_INTERVALO: begin
                if (fim_intervalo) state_next = ligar ? PREPARACAO : INICIAL;
            end
            FIM_VARREDURA: begin
                pronto     = 1'b1;
                state_next = INICIAL;
            end
            default: begin
                db_estado  = 4'hF;
                state_next = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digito  <= '0;
            posicao <= '0;
            sentido <= 1'b1;
            int_cnt <= '0;
        end else begin
            case (state)
                PREPARACAO:     digito <= '0;
                PROXIMO_DIGITO: digito <= digito + DW'(1);
                PROXIMA_POSICAO: begin
                    int_cnt <= '0;
                    if (sentido) begin
                        if (posicao == PW'(N_POSICOES - 1)) begin
                            sentido <= 1'b0;
                            posicao <= posicao - PW'(1);
                        end else begin
                            posicao <= posicao + PW'(1);
                        end
                    end else begin
                        if (posicao == '0) begin
                            sentido <= 1'b1;
                            posicao <= posicao + PW'(1);
                        end else begin
                            posicao <= posicao - PW'(1);
                        end
                    end
                end
                ESPERA_INTERVALO: if (!fim_intervalo) int_cnt <= int_cnt + IW'(1);
                default: ;
            endcase
            // idle always restarts the sweep from position 0 going up
            if (state_next == INICIAL) begin
                posicao <= '0;
                sentido <= 1'b1;
            end
        end
    end

`ifdef SONAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    assign fim_timeout = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt      <= '0;
            erro_medida <= 1'b0;
        end else begin
            case (state)
                PREPARACAO: begin
                    to_cnt      <= '0;
                    erro_medida <= 1'b0;
                end
                ESPERA_MEDIDA:  if (!fim_medida && !fim_timeout) to_cnt <= to_cnt + TW'(1);
                TIMEOUT_MEDIDA: erro_medida <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign fim_timeout    = 1'b0;
    assign erro_medida    = 1'b0;
`endif

endmodule
